// File: rtl/word_pkg.sv
// word_pkg: word type shared by the 4->6 mapping stage and its capture FIFO.
package word_pkg;
  localparam int DATA_W = 6;
  typedef logic [DATA_W-1:0] word_t;
  localparam word_t ZERO = '0;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that holds at all-ones; clr beats inc.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/word_capture_fifo.sv
// word_capture_fifo: valid/ready capture FIFO for mapped words, counting words with the AND-term bit set.
module word_capture_fifo
  import word_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   level,
  input  logic                     clr_cnt,
  output logic [CNT_W-1:0]         msb_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_ptr, rd_ptr;
  word_t mem [DEPTH];
  logic push, pop;
  assign in_ready  = level != (AW+1)'(DEPTH);
  assign out_valid = level != '0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : ZERO;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
  // storage carries no reset; occupancy alone decides what is valid
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_data;
  sat_counter #(.W(CNT_W)) u_msb_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr_cnt),
    .inc  (push & in_data[DATA_W-1]),
    .q    (msb_cnt)
  );
endmodule

// File: tb/tb_word_capture_fifo.sv
// tb_word_capture_fifo: random and directed stimulus against a queue-based reference model with a scoreboard monitor.
module tb_word_capture_fifo;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0, clr_cnt = 0;
  logic [5:0] in_data = 0, out_data;
  logic [2:0] level;
  logic [CNT_W-1:0] msb_cnt;
  int n_checks = 0, n_fail = 0;
  logic [5:0] exp_q[$];
  int occ = 0, cnt = 0;
  word_capture_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .level(level),
    .clr_cnt(clr_cnt), .msb_cnt(msb_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask
  // reference model: occupancy, expected word order and counter, from the handshake rules
  always @(posedge clk) begin
    if (!rst_n) begin
      occ = 0; exp_q.delete(); cnt = 0;
    end else begin
      automatic bit acc = in_valid && occ < DEPTH;
      automatic bit tak = out_ready && occ > 0;
      if (acc) exp_q.push_back(in_data);
      occ = occ + int'(acc) - int'(tak);
      if (clr_cnt) cnt = 0;
      else if (acc && in_data[5] && cnt < (1 << CNT_W) - 1) cnt++;
    end
  end
  always @(negedge rst_n) begin
    occ = 0; exp_q.delete(); cnt = 0;
  end
  // monitor: compares presented state and scores each word the consumer takes
  always @(negedge clk) if (rst_n) begin
    chk("level", 32'(level), 32'(occ));
    chk("out_valid", 32'(out_valid), 32'(occ > 0));
    chk("in_ready", 32'(in_ready), 32'(occ < DEPTH));
    chk("msb_cnt", 32'(msb_cnt), 32'(cnt));
    if (occ == 0) chk("out_data_empty", 32'(out_data), 0);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
      else chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
    end
  end
  task automatic drive(input logic v, input logic [5:0] d, input logic r, input logic c);
    in_valid = v; in_data = d; out_ready = r; clr_cnt = c;
    @(posedge clk);
    #1;
  endtask
  initial begin
    in_valid = 1; in_data = 6'h30;
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_msb_cnt", 32'(msb_cnt), 0);
    @(posedge clk); @(posedge clk); #1;
    chk("rst_hold_level", 32'(level), 0);
    in_valid = 0;
    rst_n = 1;
    drive(1, 6'h30, 0, 0);
    chk("single_out", 32'(out_data), 32'h30);
    chk("single_cnt", 32'(msb_cnt), 1);
    drive(0, 0, 1, 0);
    chk("single_pop_level", 32'(level), 0);
    chk("single_pop_data", 32'(out_data), 0);
    foreach (exp_q[i]) ;
    drive(1, 6'h30, 0, 0);
    drive(1, 6'h18, 0, 0);
    drive(1, 6'h08, 0, 0);
    drive(1, 6'h30, 0, 0);
    chk("fill_level", 32'(level), 4);
    chk("fill_in_ready", 32'(in_ready), 0);
    chk("fill_cnt", 32'(msb_cnt), 3);
    drive(1, 6'h3F, 0, 0);
    chk("fill_ignored", 32'(level), 4);
    chk("fill_head", 32'(out_data), 32'h30);
    drive(1, 6'h3F, 1, 0);
    chk("full_pop_no_bypass", 32'(level), 3);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 0);
    chk("drained", 32'(level), 0);
    drive(1, 6'h11, 0, 0);
    drive(1, 6'h22, 0, 0);
    drive(1, 6'h38, 1, 0);
    chk("concurrent_level", 32'(level), 2);
    for (int i = 0; i < 12; i++) drive(1, 6'($urandom), 1, 0);
    chk("stream_level", 32'(level), 2);
    for (int i = 0; i < 300; i++)
      drive($urandom_range(0, 1), 6'($urandom), $urandom_range(0, 1), $urandom_range(0, 15) == 0);
    drive(0, 0, 0, 1);
    for (int i = 0; i < 300; i++) drive(1, 6'h20, 1, 0);
    chk("cnt_saturated", 32'(msb_cnt), 32'hFF);
    drive(1, 6'h20, 1, 0);
    chk("cnt_holds", 32'(msb_cnt), 32'hFF);
    drive(1, 6'h20, 1, 1);
    chk("cnt_clr_priority", 32'(msb_cnt), 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 0);
    drive(1, 6'h01, 0, 0);
    drive(1, 6'h02, 0, 0);
    drive(1, 6'h03, 0, 0);
    chk("pre_reset_level", 32'(level), 3);
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("async_out_valid", 32'(out_valid), 0);
    chk("async_level", 32'(level), 0);
    chk("async_out_data", 32'(out_data), 0);
    #2 rst_n = 1;
    @(posedge clk); #1;
    drive(1, 6'h2A, 0, 0);
    chk("post_reset_word", 32'(out_data), 32'h2A);
    chk("post_reset_level", 32'(level), 1);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
